// File: rtl/sram_like_mem_responder_if.sv
// Request/response bundle for the SRAM-like instruction/data memory port.
// The core side drives requests (master); the memory responder answers (slave).
interface sram_like_mem_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata, wstrb,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, wstrb,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_mem_responder.sv
// SRAM-like memory responder: accepts requests in order into a small queue and
// answers each one a fixed number of cycles after it reaches the queue head.
// Reads return the word as seen after all earlier-queued writes; writes commit
// their strobed bytes on the cycle the response is launched.
// Optional build macro RESP_RANDOM_STALL_EN adds an LFSR that randomly blocks
// acceptance and stretches the per-request wait by 0..3 cycles.
module sram_like_mem_responder #(
  parameter int unsigned MEM_AW     = 12,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  sram_like_mem_responder_if.slave    bus
);

  localparam int unsigned MEM_WORDS = 1 << MEM_AW;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned LAT_W     = $clog2(LATENCY + 4) + 1;

  typedef struct packed {
    logic              wr;
    logic [MEM_AW-1:0] idx;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
  } reqEntry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  reqEntry_t         fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  logic              notFull;

  state_t            state;
  logic [LAT_W-1:0]  cnt;
  logic [LAT_W-1:0]  waitTarget;
  logic [LAT_W-1:0]  extraWait;
  logic              acceptBlock;

  logic              dataOkQ;
  logic [31:0]       rdataQ;

  logic [31:0]       mem [MEM_WORDS];

  reqEntry_t         newEntry;
  reqEntry_t         head;
  logic              push;
  logic              pop;
  logic              lastWait;
  logic              memWe;
  logic              unusedBits;

`ifdef RESP_RANDOM_STALL_EN
  logic [15:0] lfsr;
  logic        lfsrFb;

  assign lfsrFb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // Free-running Fibonacci LFSR (taps 16,14,13,11) driving the random stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsrFb};
    end
  end

  assign acceptBlock = lfsr[0] & lfsr[1];
  assign extraWait   = LAT_W'(lfsr[3:2]);
`else
  assign acceptBlock = 1'b0;
  assign extraWait   = '0;
`endif

  // size is informational and the address is only partially decoded.
  assign unusedBits = ^{bus.size, bus.addr};

  // Acceptance uses the registered count, so a retire never frees a slot in the same cycle.
  assign bus.addr_ok = !rst && notFull && !acceptBlock;
  assign bus.data_ok = dataOkQ;
  assign bus.rdata   = rdataQ;

  assign push     = bus.req && bus.addr_ok;
  assign pop      = (state == RESP);
  assign newEntry = '{wr: bus.wr, idx: bus.addr[MEM_AW+1:2], wdata: bus.wdata, wstrb: bus.wstrb};
  assign head     = fifoMem[rdPtr];
  assign lastWait = (state == WAIT) && (cnt == waitTarget);
  assign memWe    = !rst && lastWait && head.wr;

  // Occupancy after this cycle's push/pop; simultaneous push and pop leaves it unchanged.
  always_comb begin
    countNext = count;
    unique case ({push, pop})
      2'b10:   countNext = count + CNT_W'(1);
      2'b01:   countNext = count - CNT_W'(1);
      default: countNext = count;
    endcase
  end

  // Request queue storage; only the pointers are reset, stale entries are never read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr] <= newEntry;
    end
  end

  // Backing memory: strobed bytes of the head write land as its response is launched.
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (head.wstrb[b]) begin
          mem[head.idx][8*b +: 8] <= head.wdata[8*b +: 8];
        end
      end
    end
  end

  // Queue pointers/occupancy plus the service FSM with its registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      notFull    <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      waitTarget <= LAT_W'(LATENCY);
      dataOkQ    <= 1'b0;
      rdataQ     <= '0;
    end else begin
      dataOkQ <= 1'b0;
      rdataQ  <= '0;

      if (push) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count   <= countNext;
      notFull <= (countNext < CNT_W'(FIFO_DEPTH));

      unique case (state)
        IDLE: begin
          if (push) begin
            state      <= WAIT;
            cnt        <= LAT_W'(1);
            waitTarget <= LAT_W'(LATENCY) + extraWait;
          end
        end
        WAIT: begin
          if (lastWait) begin
            // Array read is launched here so rdata is valid during the response cycle.
            state   <= RESP;
            dataOkQ <= 1'b1;
            rdataQ  <= head.wr ? 32'h0 : mem[head.idx];
          end else begin
            cnt <= cnt + LAT_W'(1);
          end
        end
        RESP: begin
          if ((count > CNT_W'(1)) || push) begin
            state      <= WAIT;
            cnt        <= LAT_W'(1);
            waitTarget <= LAT_W'(LATENCY) + extraWait;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
